// File: rtl/ru_pkg.sv
// Shared types and constants for the ru load/store unit: FSM states,
// RV32I funct3 size codes and the size/sign decode helpers.
package ru_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    DONE
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } lsu_size_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Undefined encodings (011, 110, 111) fall through to a full word.
  function automatic lsu_size_t f3_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return SZ_B;
      F3_H, F3_HU: return SZ_H;
      default:     return SZ_W;
    endcase
  endfunction

  function automatic logic f3_signed(input logic [2:0] f3);
    return ~f3[2];
  endfunction

endpackage

// File: rtl/ru_lsu_if.sv
// Bus bundle around ru_lsu: core request/response plus the data RAM port.
// master = surrounding system (core + RAM), slave = the load/store unit.
interface ru_lsu_if;
  logic        req_read;
  logic        req_write;
  logic [2:0]  funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] rdata;
  logic        done;
  logic        stall;
  logic        err;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_we;
  logic [31:0] ram_rdata;
  logic        ram_busy;

  modport master (
    output req_read, req_write, funct3, req_addr, req_wdata, ram_rdata, ram_busy,
    input  rdata, done, stall, err, ram_addr, ram_wdata, ram_we
  );

  modport slave (
    input  req_read, req_write, funct3, req_addr, req_wdata, ram_rdata, ram_busy,
    output rdata, done, stall, err, ram_addr, ram_wdata, ram_we
  );
endinterface

// File: rtl/ru_lsu_align.sv
// Combinational lane logic: sub-word store merge into a fetched word and
// load lane extraction with sign/zero extension.
module ru_lsu_align
  import ru_pkg::*;
(
  input  logic [31:0] store_word_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] load_word_i,
  input  lsu_size_t   size_i,
  input  logic        sign_i,
  input  logic [1:0]  offset_i,
  output logic [31:0] merged_o,
  output logic [31:0] rdata_next_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_v = load_word_i[{offset_i, 3'b000} +: 8];
  assign half_v = load_word_i[{offset_i[1], 4'b0000} +: 16];

  // NOTE: every output gets a default first, so no path through the case can infer a latch.
  always_comb begin
    merged_o = store_word_i;
    case (size_i)
      SZ_B:    merged_o[{offset_i, 3'b000} +: 8]     = wdata_i[7:0];
      SZ_H:    merged_o[{offset_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      default: merged_o = wdata_i;
    endcase
  end

  always_comb begin
    rdata_next_o = load_word_i;
    case (size_i)
      SZ_B:    rdata_next_o = {{24{sign_i & byte_v[7]}}, byte_v};
      SZ_H:    rdata_next_o = {{16{sign_i & half_v[15]}}, half_v};
      default: rdata_next_o = load_word_i;
    endcase
  end

endmodule

// File: rtl/ru_lsu.sv
// Load/store unit: turns RV32I B/H/W loads and stores into whole-word RAM
// accesses (read-modify-write for sub-word stores). Optional misaligned-access
// trap is enabled by defining LSU_MISALIGN_TRAP_EN.
module ru_lsu
  import ru_pkg::*;
(
  input  logic    clk,
  input  logic    nRst,
  ru_lsu_if.slave bus
);

  lsu_state_t  state_q, state_d;
  logic [31:0] word_q, word_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] merged;
  logic [31:0] load_next;
  lsu_size_t   size;
  logic        sign;
  logic [1:0]  offset;
  logic        req_any;
  logic        misalign;

  assign size    = f3_size(bus.funct3);
  assign sign    = f3_signed(bus.funct3);
  assign offset  = bus.req_addr[1:0];
  assign req_any = bus.req_read | bus.req_write;

`ifdef LSU_MISALIGN_TRAP_EN
  logic err_q;

  assign misalign = ((size == SZ_H) && offset[0]) || ((size == SZ_W) && (offset != 2'b00));

  // Captured as the request leaves IDLE; only meaningful while in DONE.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst)                 err_q <= 1'b0;
    else if (state_q == IDLE)  err_q <= misalign & req_any;
  end

  assign bus.err = (state_q == DONE) & err_q;
`else
  assign misalign = 1'b0;
  assign bus.err  = 1'b0;
`endif

  ru_lsu_align u_align (
    .store_word_i (word_q),
    .wdata_i      (bus.req_wdata),
    .load_word_i  (bus.ram_rdata),
    .size_i       (size),
    .sign_i       (sign),
    .offset_i     (offset),
    .merged_o     (merged),
    .rdata_next_o (load_next)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q <= IDLE;
      word_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      rdata_q <= rdata_d;
    end
  end

  // A store with load also asserted takes the store path; the read is dropped.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (req_any) begin
          if (misalign)                            state_d = DONE;
          else if (bus.req_write && size == SZ_W)  state_d = WR;
          else                                     state_d = RD;
        end
      end
      RD: begin
        if (!bus.ram_busy) begin
          word_d = bus.ram_rdata;
          if (bus.req_write) begin
            state_d = WR;
          end else begin
            state_d = DONE;
            rdata_d = load_next;
          end
        end
      end
      WR:      if (!bus.ram_busy) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.ram_we    = (state_q == WR) & ~bus.ram_busy;
    bus.done      = (state_q == DONE);
    bus.stall     = req_any & ~bus.done;
    bus.ram_addr  = {bus.req_addr[31:2], 2'b00};
    bus.ram_wdata = merged;
    bus.rdata     = rdata_q;
  end

endmodule

// File: tb/tb_ru_lsu.sv
// Self-checking bench for ru_lsu: directed vector table, randomized
// transactions against a byte-lane reference model, and a mid-access reset.
module tb_ru_lsu;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          busy;
    int          exp_done;
    int          exp_we;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [31:0] exp_mem;
  } vec_t;

  logic        clk;
  logic        nRst;
  logic [31:0] mem     [64];
  logic [31:0] ref_mem [64];
  logic [31:0] ref_rdata;
  int          errors = 0;
  int          checks = 0;

  ru_lsu_if bus ();

  ru_lsu dut (
    .clk  (clk),
    .nRst (nRst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.ram_rdata = mem[bus.ram_addr[7:2]];
  always @(posedge clk) if (bus.ram_we) mem[bus.ram_addr[7:2]] <= bus.ram_wdata;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic int f3_bytes(input logic [2:0] f3);
    if (f3 == 3'b000 || f3 == 3'b100) return 1;
    if (f3 == 3'b001 || f3 == 3'b101) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] lane_mask(input int nbytes);
    return (nbytes == 1) ? 32'h0000_00FF : 32'h0000_FFFF;
  endfunction

  function automatic int lane_shift(input int nbytes, input logic [31:0] a);
    if (nbytes == 1) return 8 * int'(a % 4);
    return 16 * int'((a % 4) / 2);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [31:0] a);
    int nb = f3_bytes(f3);
    logic [31:0] v;
    if (nb == 4) return w;
    v = (w >> lane_shift(nb, a)) & lane_mask(nb);
    if (!f3[2] && v[8*nb-1]) v = v | ~lane_mask(nb);
    return v;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [2:0] f3,
                                            input logic [31:0] a, input logic [31:0] d);
    int nb = f3_bytes(f3);
    logic [31:0] m;
    if (nb == 4) return d;
    m = lane_mask(nb) << lane_shift(nb, a);
    return (w & ~m) | ((d << lane_shift(nb, a)) & m);
  endfunction

  // Entered #1 after a rising edge; that cycle is cycle 0 of the request.
  task automatic run_txn(input vec_t v, output int done_cyc, output int we_cyc,
                         output int we_cnt, output logic [31:0] we_data,
                         output logic err_seen, output logic stall_ok);
    done_cyc = -1; we_cyc = -1; we_cnt = 0; we_data = '0; err_seen = 1'b0; stall_ok = 1'b1;
    bus.req_read  = v.rd;
    bus.req_write = v.wr;
    bus.funct3    = v.f3;
    bus.req_addr  = v.addr;
    bus.req_wdata = v.wdata;
    for (int c = 0; c < 30; c++) begin
      bus.ram_busy = (c >= 1) && (c <= v.busy);
      @(negedge clk);
      if (bus.ram_we) begin
        we_cnt++;
        we_cyc  = c;
        we_data = bus.ram_wdata;
      end
      if (bus.stall !== ~bus.done) stall_ok = 1'b0;
      if (bus.done) begin
        done_cyc = c;
        err_seen = bus.err;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    bus.req_read  = 1'b0;
    bus.req_write = 1'b0;
    bus.ram_busy  = 1'b0;
  endtask

  task automatic apply_vec(input vec_t v, input string tag);
    int dc, wc, wn;
    logic [31:0] wd;
    logic es, sok;
    run_txn(v, dc, wc, wn, wd, es, sok);
    check({tag, ".done_cyc"}, dc, v.exp_done);
    check({tag, ".we_cnt"}, wn, (v.exp_we >= 0) ? 1 : 0);
    if (v.exp_we >= 0) begin
      check({tag, ".we_cyc"}, wc, v.exp_we);
      check({tag, ".ram_wdata"}, wd, v.exp_wdata);
      check({tag, ".ram_word"}, mem[v.addr[7:2]], v.exp_mem);
      ref_mem[v.addr[7:2]] = v.exp_mem;
    end
    check({tag, ".err"}, {31'b0, es}, {31'b0, v.exp_err});
    check({tag, ".rdata"}, bus.rdata, v.exp_rdata);
    check({tag, ".stall"}, {31'b0, sok}, 32'd1);
    ref_rdata = v.exp_rdata;
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata, input int busy,
                              input int exp_done, input int exp_we, input logic [31:0] exp_wdata,
                              input logic [31:0] exp_rdata, input logic exp_err,
                              input logic [31:0] exp_mem);
    vec_t v;
    v = '{rd, wr, f3, addr, wdata, busy, exp_done, exp_we, exp_wdata, exp_rdata, exp_err, exp_mem};
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    vec_t v;
    int   nb, we_seen;
    logic mis;
    logic [31:0] pre;

    nRst          = 1'b0;
    bus.req_read  = 1'b0;
    bus.req_write = 1'b0;
    bus.funct3    = 3'b000;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.ram_busy  = 1'b0;
    for (int i = 0; i < 64; i++) begin
      mem[i]     = 32'h0101_0101 * i ^ 32'hA5C3_0F96;
      ref_mem[i] = 32'h0101_0101 * i ^ 32'hA5C3_0F96;
    end
    mem[4] = 32'h8877_6655; ref_mem[4] = 32'h8877_6655;
    mem[8] = 32'h0;         ref_mem[8] = 32'h0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset.rdata", bus.rdata, 32'h0);
    check("reset.done", {31'b0, bus.done}, 32'd0);
    check("reset.err", {31'b0, bus.err}, 32'd0);
    check("reset.ram_we", {31'b0, bus.ram_we}, 32'd0);
    check("reset.stall", {31'b0, bus.stall}, 32'd0);
    @(posedge clk); #1 nRst = 1'b1;
    @(posedge clk); #1;

    tbl.push_back(mk(1, 0, 3'b000, 32'h13, 0, 0, 2, -1, 0, 32'hFFFF_FF88, 0, 0));
    tbl.push_back(mk(1, 0, 3'b100, 32'h13, 0, 0, 2, -1, 0, 32'h0000_0088, 0, 0));
    tbl.push_back(mk(0, 1, 3'b010, 32'h20, 32'hDEAD_BEEF, 0, 2, 1, 32'hDEAD_BEEF,
                     32'h0000_0088, 0, 32'hDEAD_BEEF));
    tbl.push_back(mk(0, 1, 3'b001, 32'h22, 32'h0000_1234, 0, 3, 2, 32'h1234_BEEF,
                     32'h0000_0088, 0, 32'h1234_BEEF));
    tbl.push_back(mk(1, 0, 3'b010, 32'h10, 0, 3, 5, -1, 0, 32'h8877_6655, 0, 0));
    tbl.push_back(mk(1, 0, 3'b001, 32'h12, 0, 0, 2, -1, 0, 32'hFFFF_8877, 0, 0));
    tbl.push_back(mk(1, 0, 3'b101, 32'h10, 0, 0, 2, -1, 0, 32'h0000_6655, 0, 0));
    tbl.push_back(mk(0, 1, 3'b000, 32'h21, 32'hFFFF_FFAB, 0, 3, 2, 32'h1234_ABEF,
                     32'h0000_6655, 0, 32'h1234_ABEF));
    tbl.push_back(mk(1, 0, 3'b011, 32'h10, 0, 0, 2, -1, 0, 32'h8877_6655, 0, 0));
    tbl.push_back(mk(1, 0, 3'b111, 32'h20, 0, 0, 2, -1, 0, 32'h1234_ABEF, 0, 0));
    tbl.push_back(mk(1, 0, 3'b010, 32'h11, 0, 0, TRAP ? 1 : 2, -1, 0,
                     TRAP ? 32'h1234_ABEF : 32'h8877_6655, TRAP, 0));
    tbl.push_back(mk(1, 1, 3'b010, 32'h24, 32'h5555_AAAA, 0, 2, 1, 32'h5555_AAAA,
                     TRAP ? 32'h1234_ABEF : 32'h8877_6655, 0, 32'h5555_AAAA));
    tbl.push_back(mk(0, 1, 3'b001, 32'h23, 32'h0000_CAFE, 0, TRAP ? 1 : 3, TRAP ? -1 : 2,
                     32'hCAFE_ABEF, TRAP ? 32'h1234_ABEF : 32'h8877_6655, TRAP,
                     32'hCAFE_ABEF));
    tbl.push_back(mk(0, 1, 3'b000, 32'h20, 32'h0000_0077, 2, 5, 4,
                     TRAP ? 32'h1234_AB77 : 32'hCAFE_AB77,
                     TRAP ? 32'h1234_ABEF : 32'h8877_6655, 0,
                     TRAP ? 32'h1234_AB77 : 32'hCAFE_AB77));

    foreach (tbl[i]) apply_vec(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 40; i++) begin
      v.wr = 1'($urandom_range(0, 1));
      v.rd = v.wr ? 1'($urandom_range(0, 1)) : 1'b1;
      v.f3 = v.wr ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      v.addr  = 32'($urandom_range(0, 63));
      v.wdata = $urandom;
      nb  = f3_bytes(v.f3);
      mis = TRAP && ((v.addr % nb) != 0);
      v.busy = mis ? 0 : $urandom_range(0, 2);
      v.exp_err   = mis;
      v.exp_rdata = ref_rdata;
      v.exp_we    = -1;
      v.exp_wdata = '0;
      v.exp_mem   = ref_mem[v.addr[7:2]];
      if (mis) begin
        v.exp_done = 1;
      end else if (v.wr) begin
        v.exp_done  = ((nb == 4) ? 2 : 3) + v.busy;
        v.exp_we    = ((nb == 4) ? 1 : 2) + v.busy;
        v.exp_wdata = ref_store(ref_mem[v.addr[7:2]], v.f3, v.addr, v.wdata);
        v.exp_mem   = v.exp_wdata;
      end else begin
        v.exp_done  = 2 + v.busy;
        v.exp_rdata = ref_load(ref_mem[v.addr[7:2]], v.f3, v.addr);
      end
      apply_vec(v, $sformatf("rnd%0d", i));
    end

    // Reset pulsed while a byte store sits in WR: the pending write must never land.
    pre = ref_mem[12];
    bus.req_write = 1'b1;
    bus.funct3    = 3'b000;
    bus.req_addr  = 32'h31;
    bus.req_wdata = 32'h0000_005A;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_mid.in_wr", {31'b0, bus.ram_we}, 32'd1);
    #1;
    nRst = 1'b0;
    bus.req_write = 1'b0;
    #1;
    check("rst_mid.ram_we", {31'b0, bus.ram_we}, 32'd0);
    check("rst_mid.done", {31'b0, bus.done}, 32'd0);
    check("rst_mid.rdata", bus.rdata, 32'h0);
    @(posedge clk); #1 nRst = 1'b1;
    we_seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.ram_we || bus.done) we_seen++;
    end
    check("rst_mid.quiet", we_seen, 0);
    check("rst_mid.mem", mem[12], pre);
    @(posedge clk); #1;
    apply_vec(mk(1, 0, 3'b010, 32'h10, 0, 0, 2, -1, 0, ref_mem[4], 0, 0), "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
